pulse_generator: RTL and testbench



---
 rtl/pulse_generator.sv | 48 ++++
 tb/tb_pulse_generator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_generator.sv
// Programmable periodic strobe: one-cycle high pulse on out every `ticks` cycles while ena is high.
// ticks = 0 or ena = 0 holds the block idle with the counter cleared, so a re-enable restarts a full period.
module pulse_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] ticks,
    output logic         out
);

    logic [N-1:0] counter;
    logic [N-1:0] counter_next;
    logic [N-1:0] ticks_m1;
    logic         out_next;
    logic         idle;
    logic         wrap;

    assign ticks_m1 = ticks - 1'b1;
    assign idle     = !ena || (ticks == '0);
    // >= rather than == so a live shrink of ticks below the count wraps at once instead of running through 2^N.
    assign wrap     = (counter >= ticks_m1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        counter_next = counter + 1'b1;
        out_next     = 1'b0;
        if (idle) begin
            counter_next = '0;
        end else if (wrap) begin
            counter_next = '0;
            out_next     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            counter <= '0;
            out     <= 1'b0;
        end else begin
            counter <= counter_next;
            out     <= out_next;
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator (N = 7, 12 MHz clock): vector table, directed corner cases,
// and randomized stimulus compared every cycle against an elapsed-cycle reference model.
`timescale 1ns/1ps
module tb_pulse_generator;

    localparam int N = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [N-1:0] ticks;
    logic         out;

    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: number of enabled edges seen since the current period began.
    int   m_elapsed = 0;
    logic m_out     = 1'b0;

    typedef struct {
        logic         ena;
        logic [N-1:0] ticks;
        logic         exp_out;
    } vec_t;

    pulse_generator #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .ticks (ticks),
        .out   (out)
    );

    always #41.667 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge: advance the model with the inputs present at the edge, then compare out.
    task automatic step(input string name);
        @(posedge clk);
        if (!rst || !ena || ticks == 0) begin
            m_elapsed = 0;
            m_out     = 1'b0;
        end else begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed >= int'(ticks)) begin
                m_out     = 1'b1;
                m_elapsed = 0;
            end else begin
                m_out = 1'b0;
            end
        end
        #1;
        check(name, 32'(out), 32'(m_out));
    endtask

    // Steps until out is high; returns the number of edges taken (limit on timeout).
    task automatic wait_pulse(input string name, input int limit, output int n);
        n = 0;
        do begin
            step(name);
            n++;
        end while (!out && n < limit);
    endtask

    initial begin
        vec_t vecs[$];
        int   n, npulses, first, last, wide, ones, maxc;
        logic prev;

        rst   = 1'b0;
        ena   = 1'b1;
        ticks = 7'd120;

        // Reset held with ena high: nothing moves.
        for (int i = 0; i < 2; i++) begin
            step("reset_out");
            check("reset_counter", 32'(dut.counter), 0);
        end

        // Nominal 120-cycle period over 1200 edges.
        rst = 1'b1;
        npulses = 0; first = -1; last = 0; wide = 0; prev = 1'b0;
        for (int i = 1; i <= 1200; i++) begin
            step("nominal");
            if (out) begin
                npulses++;
                if (first < 0) first = i;
                else check("nominal_gap", 32'(i - last), 120);
                last = i;
                if (prev) wide++;
            end
            prev = out;
        end
        check("nominal_count", 32'(npulses), 10);
        check("nominal_first", 32'(first), 120);
        check("nominal_width", 32'(wide), 0);

        // Disable for 240 cycles, then re-enable.
        @(negedge clk);
        ena  = 1'b0;
        ones = 0;
        for (int i = 0; i < 240; i++) begin
            step("disable");
            if (out) ones++;
        end
        check("disable_ones", 32'(ones), 0);
        ena = 1'b1;
        wait_pulse("reenable", 300, n);
        check("reenable_latency", 32'(n), 120);

        // Vector table from a cleared state.
        ena = 1'b0;
        step("table_clear");
        vecs = '{
            '{1'b1, 7'd3, 1'b0}, '{1'b1, 7'd3, 1'b0}, '{1'b1, 7'd3, 1'b1},
            '{1'b1, 7'd3, 1'b0}, '{1'b1, 7'd3, 1'b0}, '{1'b0, 7'd3, 1'b0},
            '{1'b1, 7'd3, 1'b0}, '{1'b1, 7'd1, 1'b1}, '{1'b1, 7'd1, 1'b1},
            '{1'b1, 7'd0, 1'b0}, '{1'b1, 7'd2, 1'b0}, '{1'b1, 7'd2, 1'b1},
            '{1'b1, 7'd5, 1'b0}, '{1'b1, 7'd1, 1'b1}
        };
        foreach (vecs[i]) begin
            ena   = vecs[i].ena;
            ticks = vecs[i].ticks;
            step("table_model");
            check($sformatf("table_vec%0d", i), 32'(out), 32'(vecs[i].exp_out));
        end

        // Live shrink 120 -> 20 at counter 50, then grow 20 -> 100 at counter 5.
        ena = 1'b0;
        step("live_clear");
        ena   = 1'b1;
        ticks = 7'd120;
        for (int i = 0; i < 50; i++) step("live_run");
        check("live_counter50", 32'(dut.counter), 50);
        ticks = 7'd20;
        step("live_shrink");
        check("live_shrink_pulse", 32'(out), 1);
        wait_pulse("live_p20", 200, n);
        check("live_period20", 32'(n), 20);
        for (int i = 0; i < 5; i++) step("live_run5");
        check("live_counter5", 32'(dut.counter), 5);
        ticks = 7'd100;
        wait_pulse("live_grow", 200, n);
        check("live_grow_latency", 32'(n), 95);

        // ena drops exactly when the pulse would fire.
        ena = 1'b0;
        step("prio_clear");
        ena   = 1'b1;
        ticks = 7'd10;
        for (int i = 0; i < 9; i++) step("prio_run");
        ena = 1'b0;
        step("prio_drop");
        check("prio_no_pulse", 32'(out), 0);
        check("prio_counter", 32'(dut.counter), 0);
        ena = 1'b1;
        wait_pulse("prio_restart", 50, n);
        check("prio_restart_latency", 32'(n), 10);

        // ticks = 1: high every enabled cycle.
        ena = 1'b0;
        step("t1_clear");
        ena   = 1'b1;
        ticks = 7'd1;
        ones  = 0;
        for (int i = 0; i < 20; i++) begin
            step("t1");
            if (out) ones++;
        end
        check("t1_ones", 32'(ones), 20);

        // ticks = 0: never pulses.
        ticks = 7'd0;
        ones  = 0;
        for (int i = 0; i < 200; i++) begin
            step("t0");
            if (out) ones++;
        end
        check("t0_ones", 32'(ones), 0);

        // ticks = 127: maximum period, counter tops out at 126.
        ena = 1'b0;
        step("t127_clear");
        ena   = 1'b1;
        ticks = 7'd127;
        first = -1; last = 0; maxc = 0;
        for (int i = 1; i <= 400; i++) begin
            step("t127");
            if (int'(dut.counter) > maxc) maxc = int'(dut.counter);
            if (out) begin
                if (first < 0) first = i;
                else check("t127_gap", 32'(i - last), 127);
                last = i;
            end
        end
        check("t127_first", 32'(first), 127);
        check("t127_max_counter", 32'(maxc), 126);

        // Asynchronous reset mid-cycle clears out before the next edge.
        ticks = 7'd1;
        step("async_pre");
        check("async_pre_high", 32'(out), 1);
        #10;
        rst = 1'b0;
        #1;
        check("async_clear_out", 32'(out), 0);
        check("async_clear_counter", 32'(dut.counter), 0);
        step("async_hold");
        rst = 1'b1;
        step("async_release");

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) begin
                case ($urandom_range(2))
                    0:       ticks = 7'($urandom_range(0, 4));
                    1:       ticks = 7'($urandom_range(5, 30));
                    default: ticks = 7'($urandom_range(0, 127));
                endcase
            end
            ena = ($urandom_range(99) < 90);
            rst = ($urandom_range(199) != 0);
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
